// File: rtl/htree_delay_tap_calibrator_if.sv
//==============================================================================
// Module      : htree_delay_tap_calibrator_if
// Description : Control/status bundle between the slow-control registers,
//               the phase detector and the HTree delay-tap calibrator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface htree_delay_tap_calibrator_if #(
    parameter int TAP_W = 4
);
    logic             start;
    logic             pd_early;
    logic             manual_en;
    logic [TAP_W-1:0] manual_tap;
    logic [TAP_W-1:0] tap_sel;
    logic             busy;
    logic             locked;
    logic             fail;
    logic [1:0]       fail_code;

    modport master (
        output start, pd_early, manual_en, manual_tap,
        input  tap_sel, busy, locked, fail, fail_code
    );

    modport slave (
        input  start, pd_early, manual_en, manual_tap,
        output tap_sel, busy, locked, fail, fail_code
    );
endinterface

`default_nettype wire

// File: rtl/htree_delay_tap_calibrator.sv
//==============================================================================
// Module      : htree_delay_tap_calibrator
// Description : Sweeps delay taps upward from 0 and locks on the first tap
//               where the majority-voted phase detector stops reporting early.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module htree_delay_tap_calibrator #(
    parameter int TAP_W         = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int DEFAULT_TAP   = 0
) (
    input  wire logic                  clk,
    input  wire logic                  rstn,
    htree_delay_tap_calibrator_if.slave bus
);

    localparam int c_cnt_max  = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int c_cnt_w    = $clog2(c_cnt_max + 1);
    localparam int c_ones_w   = $clog2(SAMPLE_CYCLES + 1);

    localparam logic [TAP_W-1:0]    c_tap_max     = {TAP_W{1'b1}};
    localparam logic [TAP_W-1:0]    c_tap_default = TAP_W'(DEFAULT_TAP);
    localparam logic [c_cnt_w-1:0]  c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_sample_last = c_cnt_w'(SAMPLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_DECIDE = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_ones_w-1:0] r_ones;
    logic [TAP_W-1:0]    r_tap_sel;
    logic                r_busy;
    logic                r_locked;
    logic                r_fail;
    logic [1:0]          r_fail_code;

    logic                w_early;
    logic                w_can_start;

    // Majority vote: a tie (exactly half early) is treated as not early.
    assign w_early     = ((32'(r_ones) << 1) > 32'(SAMPLE_CYCLES));
    assign w_can_start = (r_state == S_IDLE) || (r_state == S_LOCKED) || (r_state == S_FAIL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ones      <= '0;
            r_tap_sel   <= c_tap_default;
            r_busy      <= 1'b0;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= 2'd0;
        end else if (bus.manual_en) begin
            // Manual override aborts any sweep and tracks manual_tap.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ones      <= '0;
            r_tap_sel   <= bus.manual_tap;
            r_busy      <= 1'b0;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE, S_LOCKED, S_FAIL: begin
                    if (bus.start && w_can_start) begin
                        r_state     <= S_SETTLE;
                        r_cnt       <= '0;
                        r_ones      <= '0;
                        r_tap_sel   <= '0;
                        r_busy      <= 1'b1;
                        r_locked    <= 1'b0;
                        r_fail      <= 1'b0;
                        r_fail_code <= 2'd0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == c_settle_last) begin
                        r_state <= S_SAMPLE;
                        r_cnt   <= '0;
                        r_ones  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_ones <= r_ones + c_ones_w'(bus.pd_early);
                    if (r_cnt == c_sample_last) begin
                        r_state <= S_DECIDE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DECIDE: begin
                    r_cnt <= '0;
                    if (w_early) begin
                        if (r_tap_sel != c_tap_max) begin
                            r_state   <= S_SETTLE;
                            r_tap_sel <= r_tap_sel + 1'b1;
                        end else begin
                            r_state     <= S_FAIL;
                            r_busy      <= 1'b0;
                            r_fail      <= 1'b1;
                            r_fail_code <= 2'd2;
                        end
                    end else if (r_tap_sel != '0) begin
                        r_state  <= S_LOCKED;
                        r_busy   <= 1'b0;
                        r_locked <= 1'b1;
                    end else begin
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_fail      <= 1'b1;
                        r_fail_code <= 2'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tap_sel   = r_tap_sel;
    assign bus.busy      = r_busy;
    assign bus.locked    = r_locked;
    assign bus.fail      = r_fail;
    assign bus.fail_code = r_fail_code;

endmodule

`default_nettype wire
